traffic_sched: RTL and testbench
================================

TRAFFIC_SCHED -- requirements
Module: traffic_sched

Interface
REQ-001 Parameter GREEN_MIN, default 4, minimum green cycles before a competing lane may take over; range 1..255.
REQ-002 Parameter GREEN_MAX, default 10, green cycles after which a competing request forces changeover; GREEN_MIN <= GREEN_MAX <= 255.
REQ-003 Parameter YEL_T, default 2, yellow duration in cycles; range 1..255.
REQ-004 Parameter ALLRED_T, default 1, all-red clearance duration in cycles; range 1..255.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req  input  4  per-lane vehicle demand, level, bit i = lane i.
REQ-008 red  output  4  per-lane red lamp, registered.
REQ-009 yel  output  4  per-lane yellow lamp, registered.
REQ-010 gre  output  4  per-lane green lamp, registered.
REQ-011 cur_lane  output  2  lane currently or last holding right-of-way.
REQ-012 phase  output  2  00 ALLRED, 01 GREEN, 10 YELLOW.

Function
REQ-013 For every lane, exactly one of red[i], yel[i], gre[i] SHALL be 1 each cycle; at most one lane is non-red.
REQ-014 pending[3:0] SHALL latch req bits (pending |= req each edge) and clear bit i on the edge lane i enters GREEN; demand = pending | req.
REQ-015 Timer SHALL be 8 bits, cleared on every state entry, incremented each cycle, saturating at 255.
REQ-016 ALLRED: on the edge where timer >= ALLRED_T-1 and demand != 0, go GREEN on the first demanding lane searching rr_ptr, rr_ptr+1, ... mod 4; otherwise stay ALLRED (idle).
REQ-017 GREEN: go YELLOW on the edge where timer >= GREEN_MIN-1 and another lane has demand, or timer >= GREEN_MAX-1 and another lane has demand; with no other demand, rest in GREEN indefinitely.
REQ-018 GREEN SHALL last at least GREEN_MIN and, under competing demand present from entry, exactly GREEN_MIN cycles; demand first appearing later changes over within one cycle once timer >= GREEN_MIN-1.
REQ-019 YELLOW SHALL last exactly YEL_T cycles then go ALLRED; rr_ptr = cur_lane+1 mod 4 on that edge.
REQ-020 Demand from the green lane itself SHALL NOT extend green beyond the changeover rules; its pending bit re-arms normally.
REQ-021 Lamp outputs SHALL reflect the new state in the cycle after the transition edge (registered, no combinational path from req).

Reset
REQ-022 With rst=1 at a rising edge: state ALLRED, red=4'b1111, yel=0, gre=0, phase=00, cur_lane=0, rr_ptr=0, pending=0, timer=0.
REQ-023 Reset asserted mid-GREEN or mid-YELLOW SHALL force all-red on that edge, with no yellow.

Configuration
REQ-024 Macro TRAFFIC_SCHED_EMERG_EN, when defined, adds inputs emg_req (1) and emg_lane (2).
REQ-025 With it: emg_req high during GREEN on another lane forces YELLOW next edge, ignoring GREEN_MIN; during GREEN on emg_lane, hold GREEN while emg_req high.
REQ-026 With it: at ALLRED exit with emg_req high, grant emg_lane regardless of rr_ptr and demand; rr_ptr is unchanged by emergency grants.
REQ-027 Without it: the ports do not exist and behaviour is REQ-013..REQ-023 only.

Verification (defaults)
REQ-028 Reset, req=4'b0100 held from first low-rst edge -> gre=4'b0100, red=4'b1011 after edge 1; stays green forever with no other demand.
REQ-029 Lane 0 green with req=4'b0011 held from entry -> 4 green cycles, 2 cycles yel=4'b0001, 1 cycle red=4'b1111, then gre=4'b0010.
REQ-030 All four lanes demanding -> grants in order 0,1,2,3,0; each green 4 cycles, full cycle 28 clocks.
REQ-031 1-cycle req pulse on lane 3 during lane 1 green -> pending holds it; lane 3 granted after lane 1 yellow/allred.
REQ-032 rst pulsed during yel=4'b0010 -> next cycle red=4'b1111, yel=0, pending=0, next grant search starts at lane 0.
REQ-033 (EMERG_EN) lane 0 green at timer=1, emg_req=1, emg_lane=2 -> yellow next edge, 2 yellow, 1 all-red, gre=4'b0100 held while emg_req high.

Source files
------------

// File: rtl/traffic_sched.sv
// Four-lane traffic light scheduler: round-robin grants with min/max green,
// yellow and all-red clearance. Define TRAFFIC_SCHED_EMERG_EN for emergency preemption.
module traffic_sched #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YEL_T     = 2,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
`ifdef TRAFFIC_SCHED_EMERG_EN
  input  logic       emg_req,
  input  logic [1:0] emg_lane,
`endif
  output logic [3:0] red,
  output logic [3:0] yel,
  output logic [3:0] gre,
  output logic [1:0] cur_lane,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    ALLRED = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_e;

  localparam logic [7:0] GMinT = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMaxT = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YelT  = 8'(YEL_T - 1);
  localparam logic [7:0] ArT   = 8'(ALLRED_T - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] rr_q, rr_d;
  logic [1:0] lane_q, lane_d;
  logic       emg_q, emg_d;
  logic [3:0] red_q, red_d;
  logic [3:0] yel_q, yel_d;
  logic [3:0] gre_q, gre_d;

  logic [3:0] demand;
  logic [3:0] other;
  logic [3:0] clr;
  logic [3:0] mask;
  logic [1:0] idx;
  logic [1:0] pick;
  logic       found;
  logic       emg_act;
  logic [1:0] emg_ln;

`ifdef TRAFFIC_SCHED_EMERG_EN
  assign emg_act = emg_req;
  assign emg_ln  = emg_lane;
`else
  assign emg_act = 1'b0;
  assign emg_ln  = 2'd0;
`endif

  always_comb begin
    demand = pend_q | req;
    other  = demand & ~(4'b0001 << lane_q);
    found  = 1'b0;
    pick   = rr_q;
    idx    = rr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && demand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    rr_d    = rr_q;
    emg_d   = emg_q;
    unique case (state_q)
      ALLRED: begin
        if (timer_q >= ArT) begin
          if (emg_act) begin
            state_d = GREEN;
            lane_d  = emg_ln;
            emg_d   = 1'b1;
          end else if (found) begin
            state_d = GREEN;
            lane_d  = pick;
            emg_d   = 1'b0;
          end
        end
      end
      GREEN: begin
        if (emg_act) begin
          if (emg_ln != lane_q) state_d = YELLOW;
        end else if ((timer_q >= GMinT || timer_q >= GMaxT) && |other) begin
          state_d = YELLOW;
        end
      end
      YELLOW: begin
        if (timer_q >= YelT) begin
          state_d = ALLRED;
          // emergency grants must not disturb the round-robin order
          if (!emg_q) rr_d = lane_q + 2'd1;
        end
      end
      default: state_d = ALLRED;
    endcase
  end

  always_comb begin
    clr = 4'b0000;
    if (state_d == GREEN && state_q != GREEN) clr = 4'b0001 << lane_d;
    pend_d = (pend_q | req) & ~clr;
    if (state_d != state_q) timer_d = 8'd0;
    else if (timer_q == 8'hFF) timer_d = timer_q;
    else timer_d = timer_q + 8'd1;
  end

  always_comb begin
    mask  = 4'b0001 << lane_d;
    gre_d = 4'b0000;
    yel_d = 4'b0000;
    if (state_d == GREEN) gre_d = mask;
    if (state_d == YELLOW) yel_d = mask;
    red_d = ~(gre_d | yel_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALLRED;
      timer_q <= 8'd0;
      pend_q  <= 4'd0;
      rr_q    <= 2'd0;
      lane_q  <= 2'd0;
      emg_q   <= 1'b0;
      red_q   <= 4'hF;
      yel_q   <= 4'h0;
      gre_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      lane_q  <= lane_d;
      emg_q   <= emg_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      gre_q   <= gre_d;
    end
  end

  assign red      = red_q;
  assign yel      = yel_q;
  assign gre      = gre_q;
  assign cur_lane = lane_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_sched.sv
// Directed self-checking bench for traffic_sched at default parameters.
// Emergency preemption is exercised when TRAFFIC_SCHED_EMERG_EN is defined.
module tb_traffic_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] red, yel, gre;
  logic [1:0] cur_lane, phase;
`ifdef TRAFFIC_SCHED_EMERG_EN
  logic       emg_req = 1'b0;
  logic [1:0] emg_lane = 2'd0;
`endif

  int tests = 0;
  int fails = 0;

  traffic_sched dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
`ifdef TRAFFIC_SCHED_EMERG_EN
    .emg_req  (emg_req),
    .emg_lane (emg_lane),
`endif
    .red      (red),
    .yel      (yel),
    .gre      (gre),
    .cur_lane (cur_lane),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic lamps(input string tag, input logic [3:0] g,
                       input logic [3:0] y);
    chk({tag, ".gre"}, gre, g);
    chk({tag, ".yel"}, yel, y);
    chk({tag, ".red"}, red, ~(g | y));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'd0;
    tick();
  endtask

  logic [3:0] eg[8] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2};
  logic [3:0] ey[8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
  logic [3:0] g4, y4;
  int p, ln;

  initial begin
    // reset state
    do_reset();
    tick();
    lamps("rst", 4'h0, 4'h0);
    chk("rst.phase", {2'b0, phase}, 4'd0);
    chk("rst.lane", {2'b0, cur_lane}, 4'd0);

    // lone demand on lane 2 rests green
    rst = 1'b0;
    req = 4'b0100;
    tick();
    lamps("solo", 4'b0100, 4'h0);
    chk("solo.phase", {2'b0, phase}, 4'd1);
    chk("solo.lane", {2'b0, cur_lane}, 4'd2);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rest.gre", gre, 4'b0100);
    end

    // late competing demand changes over at once
    req = 4'b0101;
    tick();
    lamps("late.y1", 4'h0, 4'b0100);
    chk("late.phase", {2'b0, phase}, 4'd2);
    tick();
    lamps("late.y2", 4'h0, 4'b0100);
    tick();
    lamps("late.ar", 4'h0, 4'h0);
    chk("late.arph", {2'b0, phase}, 4'd0);
    tick();
    lamps("late.g0", 4'b0001, 4'h0);

    // lane 0 then lane 1, both held from entry
    do_reset();
    rst = 1'b0;
    req = 4'b0011;
    for (int t = 0; t < 8; t++) begin
      tick();
      lamps("pair", eg[t], ey[t]);
    end
    chk("pair.lane", {2'b0, cur_lane}, 4'd1);

    // all four lanes: 0,1,2,3,0 with 7-cycle slots
    do_reset();
    rst = 1'b0;
    req = 4'hF;
    for (int t = 1; t <= 29; t++) begin
      tick();
      p  = (t - 1) % 7;
      ln = ((t - 1) / 7) % 4;
      g4 = (p < 4) ? (4'b0001 << ln) : 4'h0;
      y4 = (p >= 4 && p < 6) ? (4'b0001 << ln) : 4'h0;
      lamps("rr4", g4, y4);
    end

    // one-cycle pulse on lane 3 is remembered
    do_reset();
    rst = 1'b0;
    req = 4'b0010;
    tick();
    lamps("pulse.g1", 4'b0010, 4'h0);
    req = 4'b1010;
    tick();
    req = 4'b0010;
    lamps("pulse.t2", 4'b0010, 4'h0);
    tick();
    tick();
    lamps("pulse.t4", 4'b0010, 4'h0);
    tick();
    lamps("pulse.y", 4'h0, 4'b0010);
    tick();
    tick();
    lamps("pulse.ar", 4'h0, 4'h0);
    tick();
    lamps("pulse.g3", 4'b1000, 4'h0);
    chk("pulse.lane", {2'b0, cur_lane}, 4'd3);

    // reset during lane 1 yellow
    do_reset();
    rst = 1'b0;
    req = 4'b0011;
    for (int t = 0; t < 12; t++) tick();
    lamps("ry.pre", 4'h0, 4'b0010);
    rst = 1'b1;
    req = 4'd0;
    tick();
    lamps("ry.rst", 4'h0, 4'h0);
    chk("ry.phase", {2'b0, phase}, 4'd0);
    rst = 1'b0;
    req = 4'b0100;
    tick();
    lamps("ry.g2", 4'b0100, 4'h0);

`ifdef TRAFFIC_SCHED_EMERG_EN
    // emergency to lane 2 preempts lane 0 early in green
    do_reset();
    rst = 1'b0;
    req = 4'b0001;
    tick();
    tick();
    lamps("emg.g0", 4'b0001, 4'h0);
    emg_req  = 1'b1;
    emg_lane = 2'd2;
    tick();
    lamps("emg.y1", 4'h0, 4'b0001);
    tick();
    lamps("emg.y2", 4'h0, 4'b0001);
    tick();
    lamps("emg.ar", 4'h0, 4'h0);
    tick();
    lamps("emg.g2", 4'b0100, 4'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("emg.hold", gre, 4'b0100);
    end
    emg_req = 1'b0;
    tick();
    lamps("emg.rel", 4'h0, 4'b0100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
